// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned PC_INC = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction words are 4-byte aligned; any set low bit marks a bad target.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential increment or word-aligned redirect target.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] target_aligned;

  // Increment wraps modulo 2^ADDR_W without any flag.
  assign pc_plus4_o     = pc_i + ADDR_W'(PC_INC);
  assign target_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    pc_next_o  = pc_plus4_o;
    misalign_o = 1'b0;
    if (redirect_valid_i) begin
      pc_next_o  = target_aligned;
      misalign_o = is_misaligned(redirect_pc_i[1:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack fetch, and an instruction
// register handed to decode over a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       instr_q;
  logic              instr_valid_q;
  logic              imem_req_q;
  logic              misalign_q;
  logic              redirect_misalign;

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_plus4_o       (pc_plus4),
    .pc_next_o        (pc_d),
    .misalign_o       (redirect_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b1;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          // Redirect inputs only matter on the decode handshake; acks here are spurious.
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            pc_q          <= pc_d;
            misalign_q    <= misalign_q | redirect_misalign;
            state_q       <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign op           = instr_q[OP_MSB:OP_LSB];
  assign instr_valid  = instr_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a scoreboard of fetched words.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .op             (op),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_pc;
  logic        exp_mis;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One full fetch: wait_cyc cycles of memory latency, hold_cyc cycles of
  // decode backpressure, then a handshake with the given redirect inputs.
  task automatic fetch_one(input int wait_cyc, input logic [31:0] data, input int hold_cyc,
                           input logic rv, input logic [31:0] rpc);
    sb_entry_t e;
    for (int i = 0; i < wait_cyc; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0F00 + 32'(i);
      check_val("req_wait", 32'(imem_req), 32'd1);
      check_val("addr_wait", imem_addr, exp_pc);
      check_val("valid_wait", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    check_val("req", 32'(imem_req), 32'd1);
    check_val("addr", imem_addr, exp_pc);
    check_val("pc_plus4", pc_plus4, exp_pc + 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back('{pc: exp_pc, instr: data});
    @(negedge clk);
    imem_ack = 1'b0;
    check_val("valid_rise", 32'(instr_valid), 32'd1);
    e = sb_q.pop_front();
    check_val("instr", instr, e.instr);
    check_val("op", 32'(op), 32'(e.instr[31:26]));
    check_val("pc_hold", pc, e.pc);
    for (int i = 0; i < hold_cyc; i++) begin
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hDEAD_BEE1;
      imem_rdata     = ~data ^ 32'(i);
      imem_ack       = (i == 1);
      @(negedge clk);
      check_val("bp_instr", instr, e.instr);
      check_val("bp_valid", 32'(instr_valid), 32'd1);
      check_val("bp_req", 32'(imem_req), 32'd0);
      check_val("bp_pc", pc, e.pc);
    end
    imem_ack       = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) begin
      exp_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check_val("valid_fall", 32'(instr_valid), 32'd0);
    check_val("req_next", 32'(imem_req), 32'd1);
    check_val("addr_next", imem_addr, exp_pc);
    check_val("misalign", 32'(misalign_err), 32'(exp_mis));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = 32'h0;
    exp_mis        = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_mis", 32'(misalign_err), 32'd0);

    fetch_one(0, 32'h8C08_0004, 0, 1'b0, 32'h0);
    fetch_one(3, 32'h2108_0001, 5, 1'b0, 32'h0);
    fetch_one(0, 32'h1000_0003, 1, 1'b1, 32'h0000_0040);
    fetch_one(1, 32'h0800_0010, 0, 1'b1, 32'h0000_0043);
    fetch_one(0, 32'hAC09_0008, 2, 1'b0, 32'h0);
    fetch_one(0, 32'h0000_0000, 0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 32'h3C01_1234, 0, 1'b0, 32'h0);
    fetch_one(0, 32'h8C0A_0000, 0, 1'b1, 32'h0000_0100);

    // Reset with a request pending at pc 0x100 and an ack in the same cycle.
    check_val("pre_rst_addr", imem_addr, 32'h0000_0100);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    exp_pc   = 32'h0;
    exp_mis  = 1'b0;
    check_val("mid_rst_pc", pc, 32'h0);
    check_val("mid_rst_valid", 32'(instr_valid), 32'd0);
    check_val("mid_rst_instr", instr, 32'h0);
    check_val("mid_rst_mis", 32'(misalign_err), 32'd0);
    check_val("mid_rst_req", 32'(imem_req), 32'd1);

    fetch_one(2, 32'h2002_0005, 1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
